// File: rtl/nrisc_ula_pkg.sv
// Shared NRISC ULA definitions: opcode encodings, flag bit positions and
// field widths used by the ULA arbiter and its requesters.
package nrisc_ula_pkg;

    // Opcode field and flag vector widths
    localparam int CTRL_W = 4;
    localparam int FLG_W  = 3;

    // ULA opcodes (passed through the arbiter unchecked)
    localparam logic [CTRL_W-1:0] ULA_ADD = 4'h0;
    localparam logic [CTRL_W-1:0] ULA_SUB = 4'h1;
    localparam logic [CTRL_W-1:0] ULA_AND = 4'h2;
    localparam logic [CTRL_W-1:0] ULA_OR  = 4'h3;
    localparam logic [CTRL_W-1:0] ULA_XOR = 4'h4;
    localparam logic [CTRL_W-1:0] ULA_SHR = 4'h5;
    localparam logic [CTRL_W-1:0] ULA_SHL = 4'h6;
    localparam logic [CTRL_W-1:0] ULA_NOT = 4'h7;
    localparam logic [CTRL_W-1:0] ULA_ROR = 4'hD;
    localparam logic [CTRL_W-1:0] ULA_ROL = 4'hE;

    // Bit positions inside the {minus, zero, carry} flag vector
    localparam int FLG_CARRY = 0;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_MINUS = 2;

    // Replace the zero flag by a locally computed one, keep minus and carry
    function automatic logic [FLG_W-1:0] zero_fixed_flags(input logic [FLG_W-1:0] flags,
                                                          input logic             result_is_zero);
        logic [FLG_W-1:0] f;
        f           = flags;
        f[FLG_ZERO] = result_is_zero;
        return f;
    endfunction

endpackage

// File: rtl/nrisc_rr_arbiter.sv
// Combinational round-robin arbiter: scans the eligible vector starting at
// ptr, wrapping modulo N, and returns a one-hot grant, the winner index and
// the pointer value to use next (winner+1, or ptr unchanged when idle).
// Generic so it can front other shared NRISC resources as well.
module nrisc_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner,
    output logic          any_grant,
    output logic [PW-1:0] ptr_next
);

    // Candidate index for each scan position (ptr + k wrapped to N)
    logic [PW:0] cand;

    // First eligible requester at or after ptr wins; pointer moves past it
    always_comb begin
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(N)) begin
                cand = cand - (PW+1)'(N);
            end
            if (!any_grant && eligible[cand[PW-1:0]]) begin
                any_grant = 1'b1;
                winner    = cand[PW-1:0];
            end
        end
        if (any_grant) begin
            grant[winner] = 1'b1;
        end
        ptr_next = ptr;
        if (any_grant) begin
            ptr_next = (winner == PW'(N-1)) ? '0 : winner + PW'(1);
        end
    end

endmodule

// File: rtl/nrisc_ula_arbiter.sv
// Shares one NRISC_ULA between NREQ requesters. Requests are granted
// round-robin, the ULA's one-cycle registered latency is tracked by a single
// in-flight register, and each result lands in a per-requester buffer that
// is held until the requester takes it.
//
// Handshakes: a request transfers on a clock edge where req_valid[i] and
// req_ready[i] are both high; req_ready[i] is the combinational grant and is
// only offered when requester i has no result outstanding. A response
// transfers on an edge where rsp_valid[i] and rsp_ready[i] are both high;
// rsp_out/rsp_flags are held stable while rsp_valid[i] waits for rsp_ready[i].
//
// Build option: define NRISC_ULA_ZERO_FIX_EN to recompute the captured zero
// flag from the ULA result; otherwise the ULA flags are captured verbatim.
module nrisc_ula_arbiter
    import nrisc_ula_pkg::*;
#(
    parameter int TAM  = 16,
    parameter int NREQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [CTRL_W*NREQ-1:0]   req_ctrl,
    input  logic [TAM*NREQ-1:0]      req_a,
    input  logic [TAM*NREQ-1:0]      req_b,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [TAM*NREQ-1:0]      rsp_out,
    output logic [FLG_W*NREQ-1:0]    rsp_flags,
    output logic [CTRL_W-1:0]        ula_ctrl,
    output logic [TAM-1:0]           ula_a,
    output logic [TAM-1:0]           ula_b,
    input  logic [TAM-1:0]           ula_out,
    input  logic [FLG_W-1:0]         ula_flags
);

    localparam int PW = $clog2(NREQ);

    // One outstanding operation per requester, blocks re-issue until consumed
    logic [NREQ-1:0]  busy_q, busy_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    // Operation currently inside the ULA and who issued it
    logic             inflight_v_q, inflight_v_d;
    logic [PW-1:0]    inflight_id_q, inflight_id_d;
    // Per-requester response buffers
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [TAM-1:0]   rsp_out_q   [NREQ];
    logic [TAM-1:0]   rsp_out_d   [NREQ];
    logic [FLG_W-1:0] rsp_flags_q [NREQ];
    logic [FLG_W-1:0] rsp_flags_d [NREQ];

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic [PW-1:0]    winner;
    logic             any_grant;
    logic [PW-1:0]    ptr_next;
    logic [NREQ-1:0]  rsp_done;
    logic [NREQ-1:0]  capture;
    logic [FLG_W-1:0] cap_flags;

    // Nobody is offered a grant while reset is held
    always_comb begin
        eligible = req_valid & ~busy_q & {NREQ{~rst}};
    end

    nrisc_rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .eligible  (eligible),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .winner    (winner),
        .any_grant (any_grant),
        .ptr_next  (ptr_next)
    );

    assign req_ready = grant;

    // Steer the winner's opcode and operands to the ULA; idle cycles drive zero
    always_comb begin
        ula_ctrl = '0;
        ula_a    = '0;
        ula_b    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                ula_ctrl = req_ctrl[i*CTRL_W +: CTRL_W];
                ula_a    = req_a[i*TAM +: TAM];
                ula_b    = req_b[i*TAM +: TAM];
            end
        end
    end

    // Flags as they will be stored into the response buffer
    always_comb begin
`ifdef NRISC_ULA_ZERO_FIX_EN
        cap_flags = zero_fixed_flags(ula_flags, ula_out == '0);
`else
        cap_flags = ula_flags;
`endif
    end

    // Next-state: busy tracking, pointer, in-flight pipe and buffer capture.
    // A slot is never captured while it still holds a result, because its
    // busy bit keeps the requester from issuing again until the handshake.
    always_comb begin
        rsp_done      = rsp_valid_q & rsp_ready;
        busy_d        = (busy_q & ~rsp_done) | grant;
        rr_ptr_d      = ptr_next;
        inflight_v_d  = any_grant;
        inflight_id_d = any_grant ? winner : inflight_id_q;
        capture       = '0;
        for (int i = 0; i < NREQ; i++) begin
            capture[i]     = inflight_v_q && (inflight_id_q == PW'(i));
            rsp_valid_d[i] = (rsp_valid_q[i] & ~rsp_done[i]) | capture[i];
            rsp_out_d[i]   = capture[i] ? ula_out   : rsp_out_q[i];
            rsp_flags_d[i] = capture[i] ? cap_flags : rsp_flags_q[i];
        end
    end

    // State registers; reset drops any in-flight or buffered result
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            rr_ptr_q      <= '0;
            inflight_v_q  <= 1'b0;
            inflight_id_q <= '0;
            rsp_valid_q   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                rsp_out_q[i]   <= '0;
                rsp_flags_q[i] <= '0;
            end
        end else begin
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            inflight_v_q  <= inflight_v_d;
            inflight_id_q <= inflight_id_d;
            rsp_valid_q   <= rsp_valid_d;
            for (int i = 0; i < NREQ; i++) begin
                rsp_out_q[i]   <= rsp_out_d[i];
                rsp_flags_q[i] <= rsp_flags_d[i];
            end
        end
    end

    // Flatten the response buffers onto the output buses
    always_comb begin
        rsp_valid = rsp_valid_q;
        rsp_out   = '0;
        rsp_flags = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_out[i*TAM +: TAM]       = rsp_out_q[i];
            rsp_flags[i*FLG_W +: FLG_W] = rsp_flags_q[i];
        end
    end

endmodule

// File: tb/tb_nrisc_ula_arbiter.sv
// Bench for nrisc_ula_arbiter with four requesters and a registered ULA
// model. Drivers push the hand-computed response of each accepted request
// into exp_q; a monitor pops and compares whenever rsp_valid rises, then
// checks the held value every cycle until the response handshake.
module tb_nrisc_ula_arbiter;
    import nrisc_ula_pkg::*;

    localparam int TAM   = 16;
    localparam int NREQ  = 4;
    localparam int LIMIT = 40;
    localparam int EXP_W = 2 + 3 + 16 + 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [4*NREQ-1:0]      req_ctrl;
    logic [TAM*NREQ-1:0]    req_a;
    logic [TAM*NREQ-1:0]    req_b;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [TAM*NREQ-1:0]    rsp_out;
    logic [3*NREQ-1:0]      rsp_flags;
    logic [3:0]             ula_ctrl;
    logic [TAM-1:0]         ula_a;
    logic [TAM-1:0]         ula_b;
    logic [TAM-1:0]         ula_out;
    logic [2:0]             ula_flags;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_rsp = 0;
    int max_wait = 0;
    logic [EXP_W-1:0] exp_q[$];
    int grant_log[$];

    nrisc_ula_arbiter #(.TAM(TAM), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ctrl  (req_ctrl),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_flags (rsp_flags),
        .ula_ctrl  (ula_ctrl),
        .ula_a     (ula_a),
        .ula_b     (ula_b),
        .ula_out   (ula_out),
        .ula_flags (ula_flags)
    );

    // ---------------- clock / cycle counter ----------------
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- registered ULA model ----------------
    logic [16:0] mdl_sum;
    always_comb begin
        mdl_sum = '0;
        case (ula_ctrl)
            ULA_ADD: mdl_sum = {1'b0, ula_a} + {1'b0, ula_b};
            ULA_SUB: mdl_sum = {1'b0, ula_a} - {1'b0, ula_b};
            ULA_AND: mdl_sum = {1'b0, ula_a & ula_b};
            ULA_OR:  mdl_sum = {1'b0, ula_a | ula_b};
            ULA_XOR: mdl_sum = {1'b0, ula_a ^ ula_b};
            ULA_NOT: mdl_sum = {1'b0, ~ula_a};
            default: mdl_sum = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        ula_out   <= mdl_sum[15:0];
        ula_flags <= {mdl_sum[15], (mdl_sum[15:0] == 16'h0), mdl_sum[16]};
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one request from requester i (called at a negedge), wait for
    // the grant, record the expected response, drop valid at the next negedge.
    task automatic issue(input int i, input logic [3:0] ctrl, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] eo, input logic [2:0] ef,
                         output int acc, output int waited);
        logic got;
        req_valid[i]           = 1'b1;
        req_ctrl[i*4 +: 4]     = ctrl;
        req_a[i*TAM +: TAM]    = a;
        req_b[i*TAM +: TAM]    = b;
        waited = 0;
        acc    = -1;
        #1;
        got = req_ready[i];
        while (!got && waited < LIMIT) begin
            @(negedge clk);
            waited++;
            #1;
            got = req_ready[i];
        end
        if (got) begin
            acc = cyc;
            exp_q.push_back({2'(i), ef, eo, 32'(acc)});
            n_acc++;
            grant_log.push_back(i);
            chk("ula_ctrl_mux", 32'(ula_ctrl), 32'(ctrl));
            chk("ula_a_mux", 32'(ula_a), 32'(a));
            chk("ula_b_mux", 32'(ula_b), 32'(b));
        end else begin
            chk("grant_timeout", 32'(got), 32'd1);
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    task automatic run_req(input int id, input int t_end);
        int n;
        int acc;
        int w;
        n = 0;
        while (cyc < t_end) begin
            n++;
            issue(id, ULA_ADD, 16'(id*1000 + n), 16'(n + 1), 16'(id*1000 + 2*n + 1), 3'b000, acc, w);
            if (w > max_wait) max_wait = w;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [NREQ-1:0] held;
        logic [15:0]     held_out [NREQ];
        logic [2:0]      held_flg [NREQ];
        logic [EXP_W-1:0] e;
        int kf;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = '0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (rsp_valid[i]) begin
                        if (!held[i]) begin
                            kf = -1;
                            for (int k = 0; k < exp_q.size(); k++) begin
                                if (kf < 0 && exp_q[k][52:51] == 2'(i)) kf = k;
                            end
                            if (kf < 0) begin
                                chk("unexpected_rsp_valid", 32'(i), 32'hFFFF_FFFF);
                            end else begin
                                e = exp_q[kf];
                                exp_q.delete(kf);
                                n_rsp++;
                                chk("rsp_latency", 32'(cyc) - e[31:0], 32'd2);
                                chk("rsp_out", 32'(rsp_out[i*TAM +: TAM]), 32'(e[47:32]));
                                chk("rsp_flags", 32'(rsp_flags[i*3 +: 3]), 32'(e[50:48]));
                                held[i]     = 1'b1;
                                held_out[i] = e[47:32];
                                held_flg[i] = e[50:48];
                            end
                        end else begin
                            chk("rsp_out_held", 32'(rsp_out[i*TAM +: TAM]), 32'(held_out[i]));
                            chk("rsp_flags_held", 32'(rsp_flags[i*3 +: 3]), 32'(held_flg[i]));
                        end
                        if (rsp_ready[i]) held[i] = 1'b0;
                    end else if (held[i]) begin
                        chk("rsp_valid_dropped", 32'(i), 32'hFFFF_FFFF);
                        held[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc0, acc1, w0, w1, rel, bad;
        int acc_r1 [3];
        int wa, wb, wc;
        int t_end;

        rst       = 1'b1;
        req_valid = '1;
        req_ctrl  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;

        // Reset state, with every request asserted during reset
        repeat (2) @(negedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_out", 32'(rsp_out[31:0]), 32'd0);
        chk("reset_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("reset_ula_a", 32'(ula_a), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_ula_ctrl", 32'(ula_ctrl), 32'd0);
        chk("idle_ula_b", 32'(ula_b), 32'd0);
        @(negedge clk);

        // Test 1: single ADD, ready in the same cycle, plus flag patterns
        issue(0, ULA_ADD, 16'h0003, 16'h0004, 16'h0007, 3'b000, acc0, w0);
        chk("t1_ready_same_cycle", 32'(w0), 32'd0);
        issue(0, ULA_ADD, 16'hFFFF, 16'h0001, 16'h0000, 3'b011, acc0, w0);
        issue(1, ULA_SUB, 16'h0003, 16'h0005, 16'hFFFE, 3'b101, acc0, w0);
        issue(0, ULA_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 3'b000, acc0, w0);
        issue(1, ULA_NOT, 16'h00FF, 16'h0000, 16'hFF00, 3'b100, acc0, w0);
        repeat (5) @(negedge clk);

        // Test 2: r0 and r1 request together right after reset
        do_reset();
        fork
            issue(0, ULA_AND, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100, acc0, w0);
            issue(1, ULA_XOR, 16'h1234, 16'h00FF, 16'h12CB, 3'b000, acc1, w1);
        join
        chk("t2_r1_one_after_r0", 32'(acc1 - acc0), 32'd1);
        repeat (5) @(negedge clk);

        // Test 3: r0 holds its result, r1 streams, then r0 is released
        do_reset();
        rsp_ready[0] = 1'b0;
        rel = 0;
        fork
            begin
                issue(0, ULA_ADD, 16'd10, 16'd20, 16'd30, 3'b000, acc0, wa);
                issue(0, ULA_ADD, 16'd1, 16'd1, 16'd2, 3'b000, acc1, wb);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    issue(1, ULA_ADD, 16'(k + 1), 16'd100, 16'(k + 101), 3'b000, acc_r1[k], wc);
                end
            end
            begin
                repeat (10) @(negedge clk);
                #1;
                chk("t3_r0_rsp_held", 32'(rsp_valid[0]), 32'd1);
                chk("t3_r0_not_ready", 32'(req_ready[0]), 32'd0);
                rsp_ready[0] = 1'b1;
                rel = cyc;
            end
        join
        chk("t3_r1_spacing_a", 32'(acc_r1[1] - acc_r1[0]), 32'd3);
        chk("t3_r1_spacing_b", 32'(acc_r1[2] - acc_r1[1]), 32'd3);
        chk("t3_r0_regrant", 32'(acc1), 32'(rel + 1));
        repeat (5) @(negedge clk);

        // Test 4: reset the cycle after an accept drops the result
        do_reset();
        issue(0, ULA_ADD, 16'h0001, 16'h0002, 16'h0003, 3'b000, acc0, w0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            #2;
            chk("t4_no_rsp_valid", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        fork
            issue(0, ULA_XOR, 16'h00FF, 16'h0F0F, 16'h0FF0, 3'b000, acc0, w0);
            issue(1, ULA_ADD, 16'h0100, 16'h0200, 16'h0300, 3'b000, acc1, w1);
        join
        chk("t4_rr_ptr_reset", 32'(acc1 - acc0), 32'd1);
        repeat (5) @(negedge clk);

        // Test 5: SUB to zero on r1
        do_reset();
        issue(1, ULA_SUB, 16'h0005, 16'h0005, 16'h0000, 3'b010, acc0, w0);
        repeat (5) @(negedge clk);

        // Test 6: all four requesters continuously valid for 200 cycles
        do_reset();
        grant_log.delete();
        n_acc    = 0;
        n_rsp    = 0;
        max_wait = 0;
        t_end    = cyc + 200;
        fork
            run_req(0, t_end);
            run_req(1, t_end);
            run_req(2, t_end);
            run_req(3, t_end);
        join
        repeat (6) @(negedge clk);
        bad = 0;
        for (int k = 0; k < grant_log.size(); k++) begin
            if (grant_log[k] != k % NREQ) bad++;
        end
        chk("t6_rotation_errors", 32'(bad), 32'd0);
        chk("t6_max_wait_ok", 32'(max_wait <= NREQ), 32'd1);
        chk("t6_enough_grants", 32'(grant_log.size() >= 190), 32'd1);
        chk("t6_rsp_count", 32'(n_rsp), 32'(n_acc));
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
